data_mem: RTL and testbench

Single-port, word-organised data memory serving the core's load/store path over the `mem_in_s`/`mem_out_s` valid/yumi handshake. It sits directly downstream of the core:
- it consumes `to_mem_o` and `data_mem_addr`;
- it produces `from_mem_i`.

It holds one outstanding transaction, with a configurable response latency. It supports word and byte accesses.

---
 rtl/data_mem.sv | 147 ++++++++++++++
 tb/tb_data_mem.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// data_mem: single-port word/byte data memory on the core's valid/yumi load-store handshake.
// Latency: request sampled at t, accept pulse at t+1, response valid from t+2+latency_p.
// Backpressure: one outstanding transaction; response held until the core's yumi, new requests ignored meanwhile.

package data_mem_pkg;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

endpackage

module data_mem
  import data_mem_pkg::*;
#(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  mem_in_s     to_mem_i,
  input  logic [31:0] addr_i,
  output mem_out_s    from_mem_o,
  output logic        busy_o
);

  localparam int         DEPTH  = 1 << addr_width_p;
  localparam logic [2:0] LAT_M1 = 3'(latency_p - 1);

  typedef enum logic [1:0] {IDLE, ACCEPT, WAIT, RESP} state_t;

  state_t                    r_state;
  logic [2:0]                r_cnt;
  logic                      r_wen;
  logic                      r_bnw;
  logic [addr_width_p-1:0]   r_idx;
  logic [1:0]                r_lane;
  logic [31:0]               r_rdata;
  logic                      r_valid;
  logic                      r_yumi;
  logic [31:0]               r_mem [DEPTH];

  logic [addr_width_p-1:0]   w_idx;
  logic [1:0]                w_lane;
  logic                      w_accept;
  logic [31:0]               w_word;
  logic [7:0]                w_byte;
  logic [31:0]               w_load_data;

  // Upper address bits wrap away; latched request context is kept for visibility only.
  logic w_unused;
  assign w_unused = ^{addr_i[31:addr_width_p+2], r_wen, r_bnw, r_idx, r_lane};

  assign w_idx    = addr_i[2 +: addr_width_p];
  assign w_lane   = addr_i[1:0];
  assign w_accept = (r_state == IDLE) && to_mem_i.valid;

  // Read value for the response register: full word, zero-extended lane byte, or 0 for stores.
  always_comb begin
    w_word      = r_mem[w_idx];
    w_byte      = w_word[8*w_lane +: 8];
    w_load_data = 32'h0;
    if (!to_mem_i.wen) begin
      w_load_data = to_mem_i.byte_not_word ? {24'h0, w_byte} : w_word;
    end
  end

  // Array write on the accept edge; contents survive reset, so no reset branch here.
  always_ff @(posedge clk) begin
    if (reset && w_accept && to_mem_i.wen) begin
      if (to_mem_i.byte_not_word) begin
        r_mem[w_idx][8*w_lane +: 8] <= to_mem_i.write_data[7:0];
      end else begin
        r_mem[w_idx] <= to_mem_i.write_data;
      end
    end
  end

  // Transaction FSM with registered accept pulse, response valid and read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_wen   <= 1'b0;
      r_bnw   <= 1'b0;
      r_idx   <= '0;
      r_lane  <= 2'd0;
      r_rdata <= 32'h0;
      r_valid <= 1'b0;
      r_yumi  <= 1'b0;
    end else begin
      r_yumi <= 1'b0;
      case (r_state)
        IDLE: begin
          if (to_mem_i.valid) begin
            r_state <= ACCEPT;
            r_yumi  <= 1'b1;
            r_wen   <= to_mem_i.wen;
            r_bnw   <= to_mem_i.byte_not_word;
            r_idx   <= w_idx;
            r_lane  <= w_lane;
            r_rdata <= w_load_data;
          end
        end
        ACCEPT: begin
          if (latency_p > 0) begin
            r_state <= WAIT;
            r_cnt   <= LAT_M1;
          end else begin
            r_state <= RESP;
            r_valid <= 1'b1;
          end
        end
        WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state <= RESP;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RESP: begin
          // A valid arriving together with yumi is deliberately not accepted here.
          if (to_mem_i.yumi) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign from_mem_o = '{read_data: r_rdata, valid: r_valid, yumi: r_yumi};
  assign busy_o     = (r_state != IDLE);

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: instance 0 with latency 0, instance 1 with latency 3.
// Stimulus tasks push expected read data; a monitor pops on each new response valid.
// Handshake timing is checked inline against hand-computed cycle counts.
module tb_data_mem;
  import data_mem_pkg::*;

  logic        clk;
  logic        reset;
  mem_in_s     to_mem   [2];
  logic [31:0] addr     [2];
  mem_out_s    from_mem [2];
  logic        busy     [2];

  int checks   = 0;
  int failures = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  data_mem #(.addr_width_p(10), .latency_p(0)) dut0 (
    .clk(clk), .reset(reset), .to_mem_i(to_mem[0]), .addr_i(addr[0]),
    .from_mem_o(from_mem[0]), .busy_o(busy[0])
  );

  data_mem #(.addr_width_p(10), .latency_p(3)) dut1 (
    .clk(clk), .reset(reset), .to_mem_i(to_mem[1]), .addr_i(addr[1]),
    .from_mem_o(from_mem[1]), .busy_o(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare read data on the first cycle of every response.
  initial begin
    logic prev0, prev1;
    logic [31:0] e;
    prev0 = 1'b0;
    prev1 = 1'b0;
    forever begin
      @(negedge clk);
      if (from_mem[0].valid && !prev0) begin
        if (q0.size() == 0) check("sb0_unexpected", 32'd1, 32'd0);
        else begin e = q0.pop_front(); check("sb0_rdata", from_mem[0].read_data, e); end
      end
      if (from_mem[1].valid && !prev1) begin
        if (q1.size() == 0) check("sb1_unexpected", 32'd1, 32'd0);
        else begin e = q1.pop_front(); check("sb1_rdata", from_mem[1].read_data, e); end
      end
      prev0 = from_mem[0].valid;
      prev1 = from_mem[1].valid;
    end
  end

  // One transaction: hold = cycles valid stays high after the sampling edge,
  // ydelay = cycles the core withholds yumi, rst_resp = reset instead of yumi.
  task automatic xact(input int k, input bit wen, input bit bnw, input logic [31:0] a,
                      input logic [31:0] wdata, input logic [31:0] exp, input int lat,
                      input int hold, input int ydelay, input bit rst_resp);
    int c;
    int yumis;
    bit got;
    if (k == 0) q0.push_back(exp); else q1.push_back(exp);
    @(negedge clk);
    to_mem[k].valid         = 1'b1;
    to_mem[k].wen           = wen;
    to_mem[k].byte_not_word = bnw;
    to_mem[k].write_data    = wdata;
    addr[k]                 = a;
    @(posedge clk);
    c = 0; yumis = 0; got = 1'b0;
    while (!got && c < 30) begin
      @(negedge clk);
      c++;
      // Any second accept would now write different data.
      if (c == 1) to_mem[k].write_data = ~wdata;
      if (c == hold) to_mem[k].valid = 1'b0;
      if (from_mem[k].yumi) begin
        yumis++;
        check("yumi_cycle", 32'(c), 32'd1);
      end
      check("busy_in_flight", {31'd0, busy[k]}, 32'd1);
      if (from_mem[k].valid) got = 1'b1;
    end
    to_mem[k].valid = 1'b0;
    check("valid_latency", 32'(c), 32'(2 + lat));
    check("yumi_pulses", 32'(yumis), 32'd1);
    for (int d = 0; d < ydelay; d++) begin
      @(negedge clk);
      check("held_valid", {31'd0, from_mem[k].valid}, 32'd1);
      check("held_rdata", from_mem[k].read_data, exp);
      check("held_busy", {31'd0, busy[k]}, 32'd1);
    end
    if (rst_resp) begin
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("rst_valid", {31'd0, from_mem[k].valid}, 32'd0);
      check("rst_yumi", {31'd0, from_mem[k].yumi}, 32'd0);
      check("rst_busy", {31'd0, busy[k]}, 32'd0);
    end else begin
      to_mem[k].yumi = 1'b1;
      @(negedge clk);
      to_mem[k].yumi = 1'b0;
      check("idle_valid", {31'd0, from_mem[k].valid}, 32'd0);
      check("idle_busy", {31'd0, busy[k]}, 32'd0);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      to_mem[k] = '0;
      addr[k]   = 32'h0;
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset_valid", {31'd0, from_mem[k].valid}, 32'd0);
      check("reset_yumi", {31'd0, from_mem[k].yumi}, 32'd0);
      check("reset_rdata", from_mem[k].read_data, 32'd0);
      check("reset_busy", {31'd0, busy[k]}, 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);

    // Word store / load, latency 0.
    xact(0, 1, 0, 32'h40, 32'hDEADBEEF, 32'h0,        0, 1, 0, 0);
    xact(0, 0, 0, 32'h40, 32'h0,        32'hDEADBEEF, 0, 1, 0, 0);

    // Byte lanes.
    xact(0, 1, 0, 32'h10, 32'h11223344, 32'h0,        0, 1, 0, 0);
    xact(0, 1, 1, 32'h12, 32'hFFFFFFAB, 32'h0,        0, 1, 0, 0);
    xact(0, 0, 0, 32'h10, 32'h0,        32'h11AB3344, 0, 1, 0, 0);
    xact(0, 0, 1, 32'h13, 32'h0,        32'h00000011, 0, 1, 0, 0);
    xact(0, 0, 1, 32'h10, 32'h0,        32'h00000044, 0, 1, 0, 0);

    // Latency 3 with held response.
    xact(1, 1, 0, 32'h80, 32'h12345678, 32'h0,        3, 1, 0, 0);
    xact(1, 0, 0, 32'h80, 32'h0,        32'h12345678, 3, 1, 4, 0);

    // Valid held across ACCEPT and WAIT must not re-accept.
    xact(1, 1, 0, 32'h84, 32'hA5A50F0F, 32'h0,        3, 3, 0, 0);
    xact(1, 0, 0, 32'h84, 32'h0,        32'hA5A50F0F, 3, 1, 0, 0);

    // Address wrap.
    xact(0, 1, 0, 32'h1000, 32'h5,      32'h0,        0, 1, 0, 0);
    xact(0, 0, 0, 32'h0,    32'h0,      32'h5,        0, 1, 0, 0);

    // Reset during RESP; store persists.
    xact(0, 1, 0, 32'h20, 32'hCAFEF00D, 32'h0,        0, 1, 0, 0);
    xact(0, 0, 0, 32'h20, 32'h0,        32'hCAFEF00D, 0, 1, 1, 1);
    xact(0, 0, 0, 32'h20, 32'h0,        32'hCAFEF00D, 0, 1, 0, 0);

    repeat (2) @(negedge clk);
    check("sb0_drained", 32'(q0.size()), 32'd0);
    check("sb1_drained", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
